// File: rtl/sd_writer_pkg.sv
// Shared definitions for the SD block writer.
// Holds the writer state enum, the SD block size, the pad byte and the bank count.
// Defining SD_WRITER_PINGPONG_EN selects two buffer banks; otherwise one bank is used.
package sd_writer_pkg;

  localparam int unsigned BLOCK_BYTES = 512;
  localparam logic [7:0]  PAD_BYTE    = 8'h00;

`ifdef SD_WRITER_PINGPONG_EN
  localparam int unsigned NUM_BANKS = 2;
`else
  localparam int unsigned NUM_BANKS = 1;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StPad,
    StIssue,
    StSend,
    StFinish
  } wr_state_e;

endpackage

// File: rtl/sd_block_buffer.sv
// Byte buffer for the SD block writer: simple dual-port RAM, 8 bits x 512 per bank.
// Ports:
//   clk_i   - clock
//   we_i    - write enable for waddr_i/wdata_i
//   waddr_i - write address {bank, index}
//   wdata_i - write data
//   raddr_i - read address {bank, index}
//   rdata_o - read data, two cycles after raddr_i (registered RAM output plus one stage)
// No reset: contents survive a writer reset.
module sd_block_buffer
  import sd_writer_pkg::*;
#(
  parameter int unsigned Banks = 1,
  parameter int unsigned Aw    = $clog2(Banks * BLOCK_BYTES)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [Aw-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [Aw-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [Banks * BLOCK_BYTES];
  logic [7:0] rd_stage_q;
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rd_stage_q <= mem_q[raddr_i];
    rdata_q    <= rd_stage_q;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sd_block_writer.sv
// SD block writer: collects a byte stream into 512-byte blocks and writes each block
// through an sd_controller (write request, then one byte per ready_for_next_byte rise).
// Ports:
//   clk, rst (async, active high)
//   axiid/axiiv/axiir           - byte stream in (accepted when axiiv && axiir)
//   flush                       - pulse: zero-pad the partial block and write it
//   sd_ready, sd_ready_for_next_byte - sd_controller status
//   sd_wr, sd_din, sd_addr      - sd_controller write request, byte, block address
//   busy                        - high outside IDLE/FILL
//   block_done, blocks_written  - completion pulse and completed-block count
// Macro SD_WRITER_PINGPONG_EN: two banks, filling one while the other is written out.
module sd_block_writer
  import sd_writer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'd0,
  parameter logic [15:0] MAX_BLOCKS = 16'd65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  axiid,
  input  logic        axiiv,
  output logic        axiir,
  input  logic        flush,
  input  logic        sd_ready,
  input  logic        sd_ready_for_next_byte,
  output logic        sd_wr,
  output logic [7:0]  sd_din,
  output logic [31:0] sd_addr,
  output logic        busy,
  output logic        block_done,
  output logic [15:0] blocks_written
);

  localparam int unsigned BufAw = $clog2(NUM_BANKS * BLOCK_BYTES);
`ifdef SD_WRITER_PINGPONG_EN
  localparam logic BankStep = 1'b1;
`else
  localparam logic BankStep = 1'b0;
`endif

  // Fill side
  logic [8:0]  fill_cnt_q, fill_cnt_d;
  logic        padding_q, padding_d;
  logic        wr_bank_q, wr_bank_d;
  // Per-bank "full, waiting for or under write-out"
  logic [1:0]  pend_q, pend_d;
  // Write-out side
  wr_state_e   wstate_q, wstate_d;
  logic        rd_bank_q, rd_bank_d;
  logic [8:0]  rd_idx_q, rd_idx_d;
  logic        rfn_q;
  logic        sd_wr_q, sd_wr_d;
  logic [31:0] sd_addr_q, sd_addr_d;
  logic        block_done_q, block_done_d;
  logic [15:0] blocks_q, blocks_d;
  // Holds axiir low until the first clock edge after reset
  logic        ready_q;

  logic             accept, fill_done, finish_done, pend_wr, pend_rd, quota_ok, rfn_rise;
  logic             buf_we;
  logic [7:0]       buf_wdata, buf_rdata;
  logic [BufAw-1:0] buf_waddr, buf_raddr;
  wr_state_e        state;

  assign pend_wr = wr_bank_q ? pend_q[1] : pend_q[0];
  assign pend_rd = rd_bank_q ? pend_q[1] : pend_q[0];
  // Blocks already filled count against the limit so no bank fills that could never be written
  assign quota_ok = ({1'b0, blocks_q} + 17'(pend_q[0]) + 17'(pend_q[1])) < {1'b0, MAX_BLOCKS};
  assign axiir    = ready_q && !padding_q && !pend_wr && quota_ok;
  assign accept   = axiir && axiiv;
  assign rfn_rise = sd_ready_for_next_byte && !rfn_q;

  // Fill / pad
  always_comb begin
    fill_cnt_d = fill_cnt_q;
    padding_d  = padding_q;
    wr_bank_d  = wr_bank_q;
    buf_we     = 1'b0;
    buf_wdata  = PAD_BYTE;
    fill_done  = 1'b0;
    if (padding_q) begin
      buf_we = 1'b1;
      if (fill_cnt_q == 9'd511) fill_done = 1'b1;
      else fill_cnt_d = fill_cnt_q + 9'd1;
    end else if (accept) begin
      buf_we    = 1'b1;
      buf_wdata = axiid;
      if (fill_cnt_q == 9'd511) begin
        fill_done = 1'b1;
      end else begin
        fill_cnt_d = fill_cnt_q + 9'd1;
        // Same-cycle byte lands first; padding resumes from the updated count
        if (flush) padding_d = 1'b1;
      end
    end else if (flush && fill_cnt_q != 9'd0) begin
      padding_d = 1'b1;
    end
    if (fill_done) begin
      fill_cnt_d = '0;
      padding_d  = 1'b0;
      wr_bank_d  = wr_bank_q ^ BankStep;
    end
  end

  assign buf_waddr = BufAw'({wr_bank_q, fill_cnt_q});

  // Write-out
  always_comb begin
    wstate_d     = wstate_q;
    rd_bank_d    = rd_bank_q;
    rd_idx_d     = rd_idx_q;
    sd_wr_d      = sd_wr_q;
    sd_addr_d    = sd_addr_q;
    block_done_d = 1'b0;
    blocks_d     = blocks_q;
    finish_done  = 1'b0;
    unique case (wstate_q)
      StIdle: begin
        // Also start on the completing cycle so FILL/PAD goes straight to ISSUE
        if (pend_rd || (fill_done && wr_bank_q == rd_bank_q)) begin
          wstate_d  = StIssue;
          sd_addr_d = BASE_ADDR + 32'({blocks_q, 9'd0});
        end
      end
      StIssue: begin
        if (!sd_wr_q) begin
          if (sd_ready) sd_wr_d = 1'b1;
        end else if (!sd_ready) begin
          sd_wr_d  = 1'b0;
          wstate_d = StSend;
        end
      end
      StSend: begin
        if (rfn_rise) begin
          rd_idx_d = rd_idx_q + 9'd1;
          if (rd_idx_q == 9'd511) wstate_d = StFinish;
        end
      end
      StFinish: begin
        if (sd_ready) begin
          finish_done  = 1'b1;
          block_done_d = 1'b1;
          blocks_d     = blocks_q + 16'd1;
          rd_bank_d    = rd_bank_q ^ BankStep;
          wstate_d     = StIdle;
        end
      end
      default: wstate_d = StIdle;
    endcase
  end

  always_comb begin
    pend_d = pend_q;
    if (fill_done)   pend_d[wr_bank_q] = 1'b1;
    if (finish_done) pend_d[rd_bank_q] = 1'b0;
  end

  // Address the next index so an edge reaches sd_din in two cycles
  assign buf_raddr = BufAw'({rd_bank_q, rd_idx_d});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt_q   <= '0;
      padding_q    <= 1'b0;
      wr_bank_q    <= 1'b0;
      pend_q       <= '0;
      wstate_q     <= StIdle;
      rd_bank_q    <= 1'b0;
      rd_idx_q     <= '0;
      rfn_q        <= 1'b0;
      sd_wr_q      <= 1'b0;
      sd_addr_q    <= '0;
      block_done_q <= 1'b0;
      blocks_q     <= '0;
      ready_q      <= 1'b0;
    end else begin
      fill_cnt_q   <= fill_cnt_d;
      padding_q    <= padding_d;
      wr_bank_q    <= wr_bank_d;
      pend_q       <= pend_d;
      wstate_q     <= wstate_d;
      rd_bank_q    <= rd_bank_d;
      rd_idx_q     <= rd_idx_d;
      rfn_q        <= sd_ready_for_next_byte;
      sd_wr_q      <= sd_wr_d;
      sd_addr_q    <= sd_addr_d;
      block_done_q <= block_done_d;
      blocks_q     <= blocks_d;
      ready_q      <= 1'b1;
    end
  end

  sd_block_buffer #(
    .Banks (NUM_BANKS),
    .Aw    (BufAw)
  ) u_buf (
    .clk_i   (clk),
    .we_i    (buf_we),
    .waddr_i (buf_waddr),
    .wdata_i (buf_wdata),
    .raddr_i (buf_raddr),
    .rdata_o (buf_rdata)
  );

  always_comb begin
    if (padding_q)               state = StPad;
    else if (wstate_q != StIdle) state = wstate_q;
    else if (fill_cnt_q != 9'd0) state = StFill;
    else                         state = StIdle;
  end

  assign busy           = !(state == StIdle || state == StFill);
  assign sd_wr          = sd_wr_q;
  assign sd_din         = (wstate_q == StSend) ? buf_rdata : PAD_BYTE;
  assign sd_addr        = sd_addr_q;
  assign block_done     = block_done_q;
  assign blocks_written = blocks_q;

endmodule
